palette_lookup: RTL

- Sits directly downstream of the 32x16 palette RAM, on the display pixel path.
- Takes a per-pixel 5-bit colour index from the layer compositor and drives the palette read address.
- Registers the 12-bit RGB read data, applies a global brightness fade, forces black during blanking, and delay-matches the sync signals to the colour output.
- Includes a frame-paced fade state machine that ramps brightness toward a programmed target level.

---
 rtl/palette_lookup.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/palette_lookup.sv
// palette_lookup: display pixel-path stage downstream of the 32x16 palette RAM.
// Selects the palette read address (pixel or border index), registers the RGB
// read data with a global brightness fade, blacks out blanking and non-shown
// pixels, and delay-matches hsync/vsync/blank to the colour output (2 cycles).
// A frame-paced fade state machine ramps the brightness level toward a target.
//
// Ports:
//   clk_i, rst_i                 pixel clock, synchronous active-high reset
//   pix_valid_i, pix_index_i     active pixel and its colour index
//   pix_border_i, border_index_i border pixel flag and border colour index
//   hsync_i, vsync_i, blank_i    sync/blank aligned with the pixel inputs
//   pal_rd_addr_o, pal_rd_en_o   palette RAM read port (combinational)
//   pal_rd_data_i                palette data one cycle after the address
//   fade_start_i, fade_target_i  load a new fade target (saturates at 16)
//   fade_level_o, fade_busy_o    current brightness level, ramp in progress
//   red_o, green_o, blue_o       scaled colour output
//   hsync_o, vsync_o, blank_o    sideband delayed to match the colour
module palette_lookup #(
    parameter int unsigned FADE_STEP_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pix_valid_i,
    input  logic [4:0]  pix_index_i,
    input  logic        pix_border_i,
    input  logic [4:0]  border_index_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        blank_i,
    output logic [4:0]  pal_rd_addr_o,
    output logic        pal_rd_en_o,
    input  logic [15:0] pal_rd_data_i,
    input  logic        fade_start_i,
    input  logic [4:0]  fade_target_i,
    output logic [4:0]  fade_level_o,
    output logic        fade_busy_o,
    output logic [3:0]  red_o,
    output logic [3:0]  green_o,
    output logic [3:0]  blue_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o
);

    localparam int unsigned LVL_W   = 5;
    localparam int unsigned CH_W    = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PROD_W  = 8;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(16);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } fade_state_t;

    fade_state_t       state;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  target;
    logic [CNT_W-1:0]  frame_cnt;
    logic              vsync_prev;

    logic              shown;
    logic              vsync_edge;
    logic              step_now;
    logic [LVL_W-1:0]  sat_target;
    logic [LVL_W-1:0]  eff_target;
    logic [LVL_W-1:0]  step_level;

    logic              hsync_d1;
    logic              vsync_d1;
    logic              blank_d1;
    logic              shown_d1;
    logic              black;

    // Palette bits [15:12] carry no colour.
    logic              unused_pal_hi;
    assign unused_pal_hi = ^pal_rd_data_i[15:12];

    // channel * level / 16 with rounding; 15*16+8 = 248 fits in 8 bits
    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [LVL_W-1:0] l);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(l) + PROD_W'(8);
        return p[PROD_W-1:4];
    endfunction

    // Palette read port
    assign shown         = pix_valid_i | pix_border_i;
    assign pal_rd_addr_o = pix_border_i ? border_index_i : pix_index_i;
    assign pal_rd_en_o   = shown;

    assign fade_level_o  = level;
    assign fade_busy_o   = (state == RAMP);

    // Fade helpers: a retarget coinciding with a step edge steps toward the new target
    assign sat_target = (fade_target_i > LVL_FULL) ? LVL_FULL : fade_target_i;
    assign vsync_edge = vsync_i & ~vsync_prev;
    assign eff_target = fade_start_i ? sat_target : target;
    assign step_now   = (state == RAMP) && vsync_edge && (frame_cnt == CNT_LAST);

    always_comb begin
        step_level = level;
        if (level < eff_target) begin
            step_level = LVL_W'(level + LVL_W'(1));
        end else if (level > eff_target) begin
            step_level = LVL_W'(level - LVL_W'(1));
        end
    end

    // Fade state machine
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            level      <= LVL_FULL;
            target     <= LVL_FULL;
            frame_cnt  <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync_i;
            unique case (state)
                IDLE: begin
                    if (fade_start_i) begin
                        target <= sat_target;
                        if (sat_target != level) begin
                            state     <= RAMP;
                            frame_cnt <= '0;
                        end
                    end
                end
                RAMP: begin
                    if (fade_start_i) begin
                        target <= sat_target;
                    end
                    if (step_now) begin
                        frame_cnt <= '0;
                        level     <= step_level;
                        if (step_level == eff_target) begin
                            state <= IDLE;
                        end
                    end else begin
                        if (vsync_edge) begin
                            frame_cnt <= CNT_W'(frame_cnt + CNT_W'(1));
                        end
                        if (fade_start_i && (sat_target == level)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign black = blank_d1 | ~shown_d1;

    // Sideband delay stage 1 and the output register (stage 2)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_d1 <= 1'b0;
            vsync_d1 <= 1'b0;
            blank_d1 <= 1'b1;
            shown_d1 <= 1'b0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
            blank_o  <= 1'b1;
            red_o    <= '0;
            green_o  <= '0;
            blue_o   <= '0;
        end else begin
            hsync_d1 <= hsync_i;
            vsync_d1 <= vsync_i;
            blank_d1 <= blank_i;
            shown_d1 <= shown;
            hsync_o  <= hsync_d1;
            vsync_o  <= vsync_d1;
            blank_o  <= blank_d1;
            red_o    <= black ? '0 : scale(pal_rd_data_i[11:8], level);
            green_o  <= black ? '0 : scale(pal_rd_data_i[7:4], level);
            blue_o   <= black ? '0 : scale(pal_rd_data_i[3:0], level);
        end
    end

endmodule
